dram_arbiter: RTL
=================

Name: dram_arbiter

Overview:
- Shares the single-port data RAM (dram) between two requesters: port 0 is the CPU data port, port 1 is a secondary master such as a DMA or debug loader.
- Each access is registered and sequenced through a 4-state FSM, then completed with a one-cycle ack pulse on the winning port.
- Sits in the system top between cpu, dram and the secondary master.
- All state advances only when i_clk_en is high.

Parameters:
- AW, 10, RAM word-address width.
- DW, 32, data width.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_clk_en  in  1  clock enable; when low, all registers hold
- i_m0_req  in  1  port 0 request, held high until ack
- i_m0_we  in  1  port 0 write enable (1 = write)
- i_m0_addr  in  AW  port 0 word address
- i_m0_wdata  in  DW  port 0 write data
- o_m0_ack  out  1  port 0 completion pulse
- o_m0_rdata  out  DW  port 0 read data, valid while o_m0_ack=1
- i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, o_m1_ack, o_m1_rdata: same as port 0, for port 1
- o_ram_cs  out  1  RAM chip select
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  AW  RAM address
- o_ram_wdata  out  DW  RAM write data
- i_ram_rdata  in  DW  RAM read data, valid one enabled cycle after cs

Behaviour:
- Reset (when i_rst=1 at an edge, regardless of i_clk_en):
  - state=IDLE, all outputs 0, last_grant=1 (so port 0 wins the first tie).
- FSM states:
  - IDLE: sample requests. If any req is high, choose winner, latch its we/addr/wdata into o_ram_*, set o_ram_cs=1, go to CMD. Otherwise stay in IDLE.
  - CMD: o_ram_cs high for exactly this cycle; RAM captures the command. Next, clear cs/we and go to WAIT.
  - WAIT: i_ram_rdata is valid. Register it into the winner's rdata (reads only; writes leave rdata unchanged). Set the winner's ack=1 and go to ACK.
  - ACK: ack high for exactly one enabled cycle. Clear ack, update last_grant=winner, go to IDLE. Requests are not sampled in this state.
- Latency and throughput:
  - Ack is asserted 3 enabled cycles after the edge on which req is first sampled in IDLE.
  - Minimum 4 enabled cycles per transaction.
- Handshake:
  - The requester keeps req, we, addr and wdata stable until it sees ack.
  - The requester drops req on the edge where it sees ack, or keeps it high to request a new transaction, which is re-sampled in IDLE.
  - Changing a request's fields mid-flight has no effect; values are latched in IDLE.
- Arbitration:
  - Both reqs high in IDLE: the port that is not last_grant wins (round-robin, see optional feature).
  - Exactly one req high: that port wins.
- The non-winning request stays pending; the arbiter never drops it and never acks the loser.
- o_ram_wdata and o_ram_addr hold their values after CMD until the next grant; only cs/we are cleared.
- i_clk_en low in any state: state, outputs and ack all freeze. An ack may therefore last longer than one clock, but never more than one enabled cycle.
- Reset mid-transaction: the FSM aborts to IDLE with no ack issued. A write already presented in CMD may have been committed by the RAM.
- Address/width: addresses pass through unmodified, with no range checking or wrap logic.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: tie-break as described, alternating on last_grant.
- Undefined: fixed priority, port 0 always wins ties. The last_grant register is removed, and port 1 may starve under continuous port 0 requests.

Test Plan:
- Port 0 write then read, idle port 1:
  - m0 writes addr 0x005, data 0xDEADBEEF. Expect o_ram_cs for 1 cycle with we=1, addr=0x005; o_m0_ack 3 cycles after the req sample.
  - m0 then reads 0x005. Expect o_m0_rdata=0xDEADBEEF with ack; o_m1_ack stays 0.
- Simultaneous requests, ARB_ROUND_ROBIN_EN defined:
  - m0 and m1 both hold read req continuously.
  - Expect grant order m0, m1, m0, m1, with acks 4 cycles apart.
- Same stimulus, macro undefined:
  - m0 acked every 4 cycles; m1 receives no ack until m0 drops req, then m1 is acked 3 cycles later.
- Clock-enable stall:
  - Drop i_clk_en for 5 cycles during WAIT.
  - Expect cs/ack frozen, then ack after i_clk_en returns, lasting exactly one enabled cycle; rdata correct.
- Reset mid-operation:
  - Assert i_rst during CMD of an m1 read.
  - Expect all outputs 0 on the next edge, no o_m1_ack. After reset, a pending m1 req is re-sampled and completes normally.
- Back-to-back from one port:
  - m1 holds req through ack with new addr 0x3FF.
  - Expect a second transaction to start in the following IDLE, with o_ram_addr=0x3FF.

Source files
------------

// File: rtl/dram_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the data RAM.
// Latency: none (wires only).
// Backpressure: requesters hold req and fields until ack; the RAM side never stalls.
//
// Signals:
//   i_m0_* / i_m1_*   request side of port 0 (CPU) and port 1 (DMA/debug)
//   o_m0_* / o_m1_*   ack pulse and read data back to each port
//   o_ram_*           command to the single-port RAM
//   i_ram_rdata       RAM read data, valid one enabled cycle after cs
// Modports: slave = arbiter view, master = surrounding system (requesters + RAM).
interface dram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          i_m0_req;
    logic          i_m0_we;
    logic [AW-1:0] i_m0_addr;
    logic [DW-1:0] i_m0_wdata;
    logic          o_m0_ack;
    logic [DW-1:0] o_m0_rdata;

    logic          i_m1_req;
    logic          i_m1_we;
    logic [AW-1:0] i_m1_addr;
    logic [DW-1:0] i_m1_wdata;
    logic          o_m1_ack;
    logic [DW-1:0] o_m1_rdata;

    logic          o_ram_cs;
    logic          o_ram_we;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_wdata;
    logic [DW-1:0] i_ram_rdata;

    modport slave (
        input  i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata,
        output o_m0_ack, o_m0_rdata,
        input  i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata,
        output o_m1_ack, o_m1_rdata,
        output o_ram_cs, o_ram_we, o_ram_addr, o_ram_wdata,
        input  i_ram_rdata
    );

    modport master (
        output i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata,
        input  o_m0_ack, o_m0_rdata,
        output i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata,
        input  o_m1_ack, o_m1_rdata,
        input  o_ram_cs, o_ram_we, o_ram_addr, o_ram_wdata,
        output i_ram_rdata
    );
endinterface

// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of the single-port data RAM (port 0 = CPU, port 1 = DMA/debug).
// Latency: ack rises 3 enabled cycles after the req-sampling edge; 4 enabled cycles per access.
// Backpressure: loser's req stays pending until granted; i_clk_en low freezes everything.
//
// Ports: i_clk, i_rst (sync, active high), i_clk_en, bus (dram_arbiter_if.slave).
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie-break on last_grant;
// without it port 0 always wins ties and port 1 can starve.
module dram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clk_en,
    dram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // sample requests, latch winner's command
        S_CMD  = 2'd1,  // cs high, RAM captures the command
        S_WAIT = 2'd2,  // RAM read data valid, register it
        S_ACK  = 2'd3   // one enabled cycle of ack to the winner
    } state_t;

    state_t        state_q, state_d;

    // Winner and its direction are kept separately from o_ram_we, which
    // is cleared after CMD but still needed in WAIT to decide on rdata.
    logic          winner_q, winner_d;
    logic          op_we_q, op_we_d;

    logic          cs_q, cs_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

`ifdef ARB_ROUND_ROBIN_EN
    // Port granted most recently; resets to 1 so port 0 wins the first tie.
    logic          last_grant_q, last_grant_d;
`endif

    logic          any_req;
    logic          pick;

    assign any_req = bus.i_m0_req | bus.i_m1_req;

    // Winner selection; only meaningful while any_req is high.
    always_comb begin
        pick = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.i_m0_req && bus.i_m1_req) begin
            pick = ~last_grant_q;
        end else begin
            pick = bus.i_m1_req;
        end
`else
        pick = ~bus.i_m0_req;
`endif
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        op_we_d  = op_we_q;
        cs_d     = cs_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack0_d   = ack0_q;
        ack1_d   = ack1_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    winner_d = pick;
                    cs_d     = 1'b1;
                    if (pick) begin
                        we_d    = bus.i_m1_we;
                        op_we_d = bus.i_m1_we;
                        addr_d  = bus.i_m1_addr;
                        wdata_d = bus.i_m1_wdata;
                    end else begin
                        we_d    = bus.i_m0_we;
                        op_we_d = bus.i_m0_we;
                        addr_d  = bus.i_m0_addr;
                        wdata_d = bus.i_m0_wdata;
                    end
                    state_d = S_CMD;
                end
            end

            S_CMD: begin
                // addr/wdata deliberately left on the bus until the next grant
                cs_d    = 1'b0;
                we_d    = 1'b0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (winner_q) begin
                    ack1_d = 1'b1;
                    if (!op_we_q) begin
                        rdata1_d = bus.i_ram_rdata;
                    end
                end else begin
                    ack0_d = 1'b1;
                    if (!op_we_q) begin
                        rdata0_d = bus.i_ram_rdata;
                    end
                end
                state_d = S_ACK;
            end

            S_ACK: begin
                // Requests are not looked at here; a held req is re-sampled in IDLE.
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant_d = winner_q;
`endif
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset wins over the clock enable; otherwise nothing moves while i_clk_en is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            winner_q <= 1'b0;
            op_we_q  <= 1'b0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else if (i_clk_en) begin
            state_q  <= state_d;
            winner_q <= winner_d;
            op_we_q  <= op_we_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.o_ram_cs    = cs_q;
    assign bus.o_ram_we    = we_q;
    assign bus.o_ram_addr  = addr_q;
    assign bus.o_ram_wdata = wdata_q;
    assign bus.o_m0_ack    = ack0_q;
    assign bus.o_m0_rdata  = rdata0_q;
    assign bus.o_m1_ack    = ack1_q;
    assign bus.o_m1_rdata  = rdata1_q;

endmodule
